maxpool_2x2_stream: RTL and testbench

- Streaming 2x2 stride-2 max-pooling stage that sits directly downstream of the convolution output stream.
- Accepts one 18-bit sign-magnitude feature-map pixel per valid cycle in row-major order.
- Buffers horizontal pair maxima from even rows, then emits one pooled pixel per 2x2 window in row-major order to the next layer.
- All comparisons use the team's compare_2_2 sign-magnitude max cell.

---
 rtl/maxpool_2x2_stream_pkg.sv | 12 +
 rtl/maxpool_2x2_stream_if.sv | 24 ++
 rtl/compare_2_2.sv | 32 +++
 rtl/maxpool_2x2_stream_cmp.sv | 26 ++
 rtl/maxpool_2x2_stream.sv | 83 ++++++++
 tb/tb_maxpool_2x2_stream.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared constants for the 2x2 max-pooling stages: pixel format and LeNet map sizes.
package maxpool_2x2_stream_pkg;

    localparam int unsigned DATA_W   = 18;
    localparam int unsigned SIGN_BIT = DATA_W - 1;

    localparam int unsigned C1_W = 28;
    localparam int unsigned C1_H = 28;
    localparam int unsigned C3_W = 10;
    localparam int unsigned C3_H = 10;

endpackage

// File: rtl/maxpool_2x2_stream_if.sv
// Pixel stream in, pooled pixel stream out, plus end-of-frame pulse.
interface maxpool_2x2_stream_if
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int unsigned DATA_W = maxpool_2x2_stream_pkg::DATA_W
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              frame_done;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, frame_done
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, frame_done
    );

endinterface

// File: rtl/compare_2_2.sv
// Sign-magnitude max cell; +0 beats -0, ties return an identical value.
module compare_2_2
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic         sa, sb;
    logic [W-2:0] ma, mb;

    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ma = a[W-2:0];
    assign mb = b[W-2:0];

    always_comb begin
        y = a;
        if (sa != sb) begin
            y = sa ? b : a;
        end else if (!sa) begin
            y = (ma >= mb) ? a : b;
        end else begin
            // Both negative: smaller magnitude is the larger value.
            y = (ma <= mb) ? a : b;
        end
    end

endmodule

// File: rtl/maxpool_2x2_stream_cmp.sv
// Horizontal pair max followed by vertical max against the buffered even-row result.
module maxpool_2x2_stream_cmp
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic [W-1:0] hold,
    input  logic [W-1:0] pix,
    input  logic [W-1:0] line,
    output logic [W-1:0] h,
    output logic [W-1:0] v
);

    compare_2_2 #(.W(W)) u_horiz (
        .a(hold),
        .b(pix),
        .y(h)
    );

    compare_2_2 #(.W(W)) u_vert (
        .a(line),
        .b(h),
        .y(v)
    );

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool: even rows fill a half-width line buffer,
// odd rows combine with it and emit one pooled pixel per window.
module maxpool_2x2_stream
    import maxpool_2x2_stream_pkg::*;
#(
    parameter int unsigned IN_W = C1_W,
    parameter int unsigned IN_H = C1_H
) (
    input logic                 clk,
    input logic                 rst,
    maxpool_2x2_stream_if.slave stream
);

    localparam int unsigned ColW = $clog2(IN_W);
    localparam int unsigned RowW = $clog2(IN_H);
    localparam int unsigned LbD  = IN_W / 2;
    localparam int unsigned LbAw = (ColW > 1) ? ColW - 1 : 1;

    logic [ColW-1:0]   col_q;
    logic [RowW-1:0]   row_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] lb_q [LbD];
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              frame_done_q;

    logic [LbAw-1:0]   lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] h, v;
    logic              last_col, last_row;

    assign lb_idx   = LbAw'(col_q >> 1);
    assign lb_rd    = lb_q[lb_idx];
    assign last_col = (col_q == ColW'(IN_W - 1));
    assign last_row = (row_q == RowW'(IN_H - 1));

    maxpool_2x2_stream_cmp #(.W(DATA_W)) u_cmp (
        .hold(hold_q),
        .pix (stream.in_data),
        .line(lb_rd),
        .h   (h),
        .v   (v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (stream.in_valid) begin
                if (!col_q[0]) begin
                    hold_q <= stream.in_data;
                end else if (row_q[0]) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= v;
                    frame_done_q <= last_row && last_col;
                end
                col_q <= last_col ? '0 : col_q + 1'b1;
                if (last_col) begin
                    row_q <= last_row ? '0 : row_q + 1'b1;
                end
            end
        end
    end

    // Line buffer is always overwritten by an even row before being read.
    always_ff @(posedge clk) begin
        if (stream.in_valid && col_q[0] && !row_q[0]) begin
            lb_q[lb_idx] <= h;
        end
    end

    assign stream.out_valid  = out_valid_q;
    assign stream.out_data   = out_data_q;
    assign stream.frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream: 4x4 instance for hand-checked cases,
// 28x28 instance for back-to-back random frames against a frame-level golden max.
module tb_maxpool_2x2_stream;
    import maxpool_2x2_stream_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    maxpool_2x2_stream_if #(.DATA_W(DATA_W)) s_if ();
    maxpool_2x2_stream_if #(.DATA_W(DATA_W)) l_if ();

    maxpool_2x2_stream #(.IN_W(4), .IN_H(4)) dut_s (
        .clk   (clk),
        .rst   (rst),
        .stream(s_if.slave)
    );

    maxpool_2x2_stream #(.IN_W(C1_W), .IN_H(C1_H)) dut_l (
        .clk   (clk),
        .rst   (rst),
        .stream(l_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int n_out    = 0;
    logic [17:0] frame [784];
    logic [17:0] got [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Ordering key: -0 just below +0, otherwise signed value order.
    function automatic int sm_key(input logic [17:0] x);
        int m;
        m = int'(x[16:0]);
        return x[17] ? -2 * m : 2 * m + 1;
    endfunction

    function automatic logic [17:0] sm_max(input logic [17:0] a, input logic [17:0] b);
        return (sm_key(a) >= sm_key(b)) ? a : b;
    endfunction

    task automatic drive(input bit lg, input bit v, input logic [17:0] d,
                         input bit ev, input logic [17:0] ed, input bit efd);
        logic        ov, ofd;
        logic [17:0] od;
        if (lg) begin
            l_if.in_valid = v;
            l_if.in_data  = d;
        end else begin
            s_if.in_valid = v;
            s_if.in_data  = d;
        end
        @(posedge clk);
        #1;
        s_if.in_valid = 1'b0;
        l_if.in_valid = 1'b0;
        ov  = lg ? l_if.out_valid  : s_if.out_valid;
        od  = lg ? l_if.out_data   : s_if.out_data;
        ofd = lg ? l_if.frame_done : s_if.frame_done;
        check_eq("out_valid", 32'(ov), 32'(ev));
        check_eq("frame_done", 32'(ofd), 32'(efd));
        if (ev) check_eq("out_data", 32'(od), 32'(ed));
        if (ov) begin
            got.push_back(od);
            n_out++;
        end
        if (ofd) fd_cnt++;
    endtask

    task automatic send_frame(input bit lg, input int w, input int h, input int n,
                              input bit gaps);
        int          r, c;
        bit          ev, efd;
        logic [17:0] ed;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) drive(lg, 1'b0, 18'h0, 1'b0, 18'h0, 1'b0);
            end
            r   = i / w;
            c   = i % w;
            ev  = (r % 2 == 1) && (c % 2 == 1);
            ed  = 18'h0;
            efd = ev && (i == w * h - 1);
            if (ev) begin
                ed = sm_max(sm_max(frame[(r-1)*w + c-1], frame[(r-1)*w + c]),
                            sm_max(frame[r*w + c-1], frame[i]));
            end
            drive(lg, 1'b1, frame[i], ev, ed, efd);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 18'h0, 1'b0, 18'h0, 1'b0);
        rst = 1'b0;
        check_eq("rst_s_valid", 32'(s_if.out_valid), 32'h0);
        check_eq("rst_s_data", 32'(s_if.out_data), 32'h0);
        check_eq("rst_s_fd", 32'(s_if.frame_done), 32'h0);
        check_eq("rst_l_valid", 32'(l_if.out_valid), 32'h0);
        check_eq("rst_l_data", 32'(l_if.out_data), 32'h0);
        check_eq("rst_l_fd", 32'(l_if.frame_done), 32'h0);
    endtask

    task automatic check_got(input string tag, input logic [17:0] e [4]);
        check_eq({tag, "_count"}, 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq(tag, 32'((k < got.size()) ? got[k] : 18'h3ffff), 32'(e[k]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] e_seq   [4] = '{18'd6, 18'd8, 18'd14, 18'd16};
        logic [17:0] e_mixed [4] = '{18'h00003, 18'h20001, 18'h00000, 18'h20000};
        logic [17:0] e_fresh [4] = '{18'd105, 18'd107, 18'd113, 18'd115};

        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        l_if.in_valid = 1'b0;
        l_if.in_data  = '0;
        do_reset();

        // Ascending 1..16, no gaps.
        for (int i = 0; i < 16; i++) frame[i] = 18'(i + 1);
        got.delete();
        fd_cnt = 0;
        send_frame(1'b0, 4, 4, 16, 1'b0);
        check_got("seq", e_seq);
        check_eq("seq_fd_cnt", 32'(fd_cnt), 32'd1);

        // Sign cases: mixed, all-negative, -0/+0, all -0.
        frame[0]  = 18'h20005; frame[1]  = 18'h00003; frame[4]  = 18'h20001; frame[5]  = 18'h20009;
        frame[2]  = 18'h20005; frame[3]  = 18'h20001; frame[6]  = 18'h20009; frame[7]  = 18'h20002;
        frame[8]  = 18'h20000; frame[9]  = 18'h00000; frame[12] = 18'h20000; frame[13] = 18'h20000;
        frame[10] = 18'h20000; frame[11] = 18'h20000; frame[14] = 18'h20000; frame[15] = 18'h20000;
        got.delete();
        send_frame(1'b0, 4, 4, 16, 1'b0);
        check_got("signs", e_mixed);

        // Random idle gaps on the ascending frame.
        for (int i = 0; i < 16; i++) frame[i] = 18'(i + 1);
        got.delete();
        send_frame(1'b0, 4, 4, 16, 1'b1);
        check_got("gaps", e_seq);

        // Partial frame, reset, then a fresh frame.
        send_frame(1'b0, 4, 4, 7, 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) frame[i] = 18'(100 + i);
        got.delete();
        send_frame(1'b0, 4, 4, 16, 1'b0);
        check_got("fresh", e_fresh);

        // Two back-to-back random 28x28 frames.
        fd_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 784; i++) frame[i] = 18'($urandom);
            n_out = 0;
            send_frame(1'b1, 28, 28, 784, 1'b0);
            check_eq("big_out_count", 32'(n_out), 32'd196);
        end
        check_eq("big_fd_cnt", 32'(fd_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
